// File: rtl/spi_master_pkg.sv
// Shared types and widths for the SPI frame initiator.
package spi_master_pkg;

  typedef enum logic [1:0] {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} spi_cmd_e;

  typedef enum logic [2:0] {IDLE, SELECT, SHIFT, HOLD, WAIT, CAPTURE, GAP} state_e;

  localparam int WORD_W  = 10;
  localparam int DATA_W  = 8;
  localparam int HDR_CYC = 12;

endpackage

// File: rtl/spi_master_shifter.sv
// Parallel-load shift-out register for the command word, plus an
// MSB-first shift-in register for the read reply.
module spi_master_shifter
  import spi_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift_out,
  input  logic              shift_in,
  input  logic [WORD_W-1:0] word,
  input  logic              miso,
  output logic              mosi_bit,
  output logic [DATA_W-1:0] cap_next
);

  logic [WORD_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load)
        tx_q <= word;
      else if (shift_out)
        tx_q <= {tx_q[WORD_W-2:0], 1'b0};
      if (shift_in)
        rx_q <= cap_next;
    end
  end

  assign mosi_bit = tx_q[WORD_W-1];
  // Includes the bit being sampled this cycle so the last capture can be
  // published in the same edge that ends CAPTURE.
  assign cap_next = {rx_q[DATA_W-2:0], miso};

endmodule

// File: rtl/spi_master_frame.sv
// SPI initiator: serialises {cmd, din} MSB-first under SS_n and, for RD_DATA
// frames, captures the 8-bit MISO reply. SCK is the system clock.
module spi_master_frame
  import spi_master_pkg::*;
#(
  parameter int MISO_LAT = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [7:0]  din,
  output logic        ready,
  output logic        busy,
  output logic        SS_n,
  output logic        MOSI,
  input  logic        MISO,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        done,
  output state_e      state_dbg
);

  // Handshake: a command transfers on a posedge where start && ready; ready
  // is high only in IDLE, and start is ignored (not queued) otherwise.

  localparam logic [3:0] SHIFT_LAST = 4'(WORD_W - 1);
  localparam logic [3:0] CAP_LAST   = 4'(DATA_W - 1);
  localparam logic [3:0] LAT_LAST   = 4'(MISO_LAT - 1);
  localparam logic [3:0] GAP_LAST   = 4'(IDLE_GAP - 1);

  state_e            state;
  logic [3:0]        cnt;
  logic              rd;
  logic              load, shift_out, shift_in;
  logic              mosi_bit;
  logic [DATA_W-1:0] cap_next;

  always_comb begin
    load      = 1'b0;
    shift_out = 1'b0;
    shift_in  = 1'b0;
    if (state == IDLE && start) load = 1'b1;
    if (state == SELECT || state == SHIFT) shift_out = 1'b1;
    if (state == CAPTURE) shift_in = 1'b1;
  end

  spi_master_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift_out (shift_out),
    .shift_in  (shift_in),
    .word      ({cmd, din}),
    .miso      (MISO),
    .mosi_bit  (mosi_bit),
    .cap_next  (cap_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rd       <= 1'b0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SELECT;
          rd    <= (spi_cmd_e'(cmd) == RD_DATA);
          cnt   <= '0;
          SS_n  <= 1'b0;
          MOSI  <= 1'b0;
          ready <= 1'b0;
          busy  <= 1'b1;
        end
        SELECT: begin
          state <= SHIFT;
          cnt   <= '0;
          MOSI  <= mosi_bit;
        end
        SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            state <= HOLD;
            cnt   <= '0;
            MOSI  <= 1'b0;
          end else begin
            cnt  <= cnt + 4'd1;
            MOSI <= mosi_bit;
          end
        end
        HOLD: begin
          cnt <= '0;
          if (!rd) begin
            state <= GAP;
            SS_n  <= 1'b1;
            done  <= 1'b1;
          end else if (MISO_LAT == 0) begin
            state <= CAPTURE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAT_LAST) begin
            state <= CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CAPTURE: begin
          if (cnt == CAP_LAST) begin
            state    <= GAP;
            cnt      <= '0;
            SS_n     <= 1'b1;
            done     <= 1'b1;
            rx_valid <= 1'b1;
            rx_data  <= cap_next;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_spi_master_frame.sv
// Bench for spi_master_frame: default instance plus a MISO_LAT=0/IDLE_GAP=3
// instance, checked against frame-level timing and content rules.
module tb_spi_master_frame;
  import spi_master_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] din = 8'h00;
  logic       miso = 1'b0;
  logic       sel = 1'b0;

  logic a_ready, a_busy, a_ss, a_mosi, a_rxv, a_done;
  logic b_ready, b_busy, b_ss, b_mosi, b_rxv, b_done;
  logic [7:0] a_rx, b_rx;
  state_e a_st, b_st;

  logic ready_o, busy_o, ss_o, mosi_o, rxv_o, done_o;
  logic [7:0] rx_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] last_rx [2];

  always #5 clk = ~clk;

  spi_master_frame u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .din(din),
    .ready(a_ready), .busy(a_busy), .SS_n(a_ss), .MOSI(a_mosi), .MISO(miso),
    .rx_data(a_rx), .rx_valid(a_rxv), .done(a_done), .state_dbg(a_st)
  );

  spi_master_frame #(.MISO_LAT(0), .IDLE_GAP(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .din(din),
    .ready(b_ready), .busy(b_busy), .SS_n(b_ss), .MOSI(b_mosi), .MISO(miso),
    .rx_data(b_rx), .rx_valid(b_rxv), .done(b_done), .state_dbg(b_st)
  );

  assign ready_o = sel ? b_ready : a_ready;
  assign busy_o  = sel ? b_busy  : a_busy;
  assign ss_o    = sel ? b_ss    : a_ss;
  assign mosi_o  = sel ? b_mosi  : a_mosi;
  assign rxv_o   = sel ? b_rxv   : a_rxv;
  assign done_o  = sel ? b_done  : a_done;
  assign rx_o    = sel ? b_rx    : a_rx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready before start"}, 32'(ready_o), 32'd1);
  endtask

  // One complete frame from IDLE; the slave reply mb is driven MSB-first
  // starting at SS_n-low cycle 13+lat. Random start pulses hit the busy window.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] d,
                           input logic [7:0] mb, input string tag);
    int low, k, lat, gap;
    logic [9:0] got;
    logic quiet;
    bit rd;
    lat = sel ? 0 : 2;
    gap = sel ? 3 : 1;
    rd  = (c == 2'b11);
    wait_ready(tag);
    start = 1'b1;
    cmd   = c;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    cmd   = 2'($urandom);
    din   = 8'($urandom);
    low   = 0;
    got   = '0;
    quiet = 1'b1;
    while (ss_o === 1'b0 && low < 64) begin
      low++;
      if (low >= 2 && low <= 11) got = {got[8:0], mosi_o};
      else if (mosi_o !== 1'b0) quiet = 1'b0;
      if (done_o !== 1'b0 || rxv_o !== 1'b0 || busy_o !== 1'b1 || ready_o !== 1'b0)
        quiet = 1'b0;
      if (rd && low >= 13 + lat && low <= 20 + lat) miso = mb[7 - (low - 13 - lat)];
      else miso = 1'($urandom);
      start = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " ss_n low cycles"}, 32'(low), 32'(HDR_CYC + (rd ? lat + DATA_W : 0)));
    chk({tag, " mosi word"}, 32'(got), 32'({c, d}));
    chk({tag, " in-frame outputs"}, 32'(quiet), 32'd1);
    chk({tag, " done at frame end"}, 32'(done_o), 32'd1);
    chk({tag, " rx_valid at frame end"}, 32'(rxv_o), 32'(rd));
    if (rd) last_rx[sel] = mb;
    chk({tag, " rx_data"}, 32'(rx_o), 32'(last_rx[sel]));
    k = 0;
    while (ready_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (done_o !== 1'b0 || rxv_o !== 1'b0 || ss_o !== 1'b1 || busy_o !== 1'b1 && ready_o !== 1'b1)
        quiet = 1'b0;
    end
    chk({tag, " ready after done"}, 32'(k), 32'(gap));
    repeat (3) begin
      @(negedge clk);
      if (ss_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) quiet = 1'b0;
    end
    chk({tag, " single pulse, no queued frame"}, 32'(quiet), 32'd1);
  endtask

  initial begin
    int low, h;
    logic [9:0] got;
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;

    // Reset held with start asserted: nothing may start.
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd = 2'($urandom);
      din = 8'($urandom);
      @(negedge clk);
      chk("reset outputs", 32'({a_ss, a_ready, a_busy, a_done, a_rxv, a_mosi, a_rx}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", 32'({a_ss, a_ready, a_busy}), 32'({1'b1, 1'b1, 1'b0}));

    run_frame(2'b00, 8'hA5, 8'h00, "wr_addr a5");
    run_frame(2'b11, 8'h00, 8'h3C, "rd_data 3c");

    // Back-to-back with start held high; cmd changes after the first accept.
    wait_ready("b2b");
    start = 1'b1;
    cmd   = 2'b01;
    din   = 8'hFF;
    @(negedge clk);
    cmd = 2'b10;
    din = 8'h10;
    low = 0;
    got = '0;
    while (ss_o === 1'b0 && low < 64) begin
      low++;
      if (low >= 2 && low <= 11) got = {got[8:0], mosi_o};
      @(negedge clk);
    end
    chk("b2b first low cycles", 32'(low), 32'(HDR_CYC));
    chk("b2b first word", 32'(got), 32'({2'b01, 8'hFF}));
    h = 0;
    while (ss_o === 1'b1 && h < 40) begin
      h++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b rise to fall", 32'(h), 32'd2);
    low = 0;
    got = '0;
    while (ss_o === 1'b0 && low < 64) begin
      low++;
      if (low >= 2 && low <= 11) got = {got[8:0], mosi_o};
      start = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b second low cycles", 32'(low), 32'(HDR_CYC));
    chk("b2b second word", 32'(got), 32'({2'b10, 8'h10}));
    repeat (6) @(negedge clk);
    chk("b2b frame count", 32'({ss_o, ready_o}), 32'({1'b1, 1'b1}));

    // Reset during SHIFT bit 5 of a WR_DATA frame.
    wait_ready("abort");
    start = 1'b1;
    cmd   = 2'b01;
    din   = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort mid-frame ss_n", 32'(ss_o), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort outputs", 32'({ss_o, done_o, rxv_o, busy_o, ready_o}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1}));
    rst_n = 1'b1;
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;
    @(negedge clk);
    chk("abort no done", 32'(done_o), 32'd0);
    run_frame(2'b00, 8'h01, 8'h00, "post-abort wr_addr 01");

    for (int i = 0; i < 8; i++)
      run_frame(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), "random lat2");

    // Second instance: MISO_LAT=0, IDLE_GAP=3.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1;
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;
    @(negedge clk);
    run_frame(2'b11, 8'h00, 8'h81, "sweep rd_data 81");
    for (int i = 0; i < 5; i++)
      run_frame(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), "random lat0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
